adc_burst_sequencer: RTL and testbench
======================================

Name: adc_burst_sequencer

Overview:
- Sequences the LTC2315 ADC interface in the sck domain: on a start request it collects a burst of conversion results and accumulates them.
- Error samples are rejected. The ADC interface is re-synchronised through its reset after repeated errors or a stall.
- Sum, count and fault status go downstream with a valid/ready handshake.
- Sits directly between the ADC interface outputs and the receiver datapath; no clock crossing.

Parameters:
- LEN_W, 8, width of burst_len_i; burst = burst_len_i+1 samples (1..256)
- TIMEOUT, 128, sck cycles without adc_valid_i in CAPTURE before resync
- MAX_CONSEC_ERR, 4, consecutive error samples that force resync
- RST_CYCLES, 4, sck cycles adc_rst_o is held high per resync
- MAX_RETRIES, 3, resyncs allowed per burst before fault

Ports:
- sck  in  1  clock (ADC serial clock domain)
- rst_n  in  1  synchronous active-low reset
- start_i  in  1  burst request, sampled in IDLE only
- burst_len_i  in  LEN_W  samples minus one, latched on accepted start
- adc_data_i  in  12  ADC interface data
- adc_valid_i  in  1  one-cycle sample strobe from ADC interface
- adc_error_i  in  1  start-bit error flag, qualified by adc_valid_i
- adc_rst_o  out  1  active-high reset to ADC interface
- busy_o  out  1  high in any state except IDLE
- sum_o  out  LEN_W+12  accumulated good samples
- count_o  out  LEN_W+1  good samples in sum_o
- fault_o  out  1  burst ended by retry exhaustion, qualified by result_valid_o
- result_valid_o  out  1  result available
- result_ready_i  in  1  downstream accept
- err_count_o  out  8  saturating count of error samples since reset

Behaviour:
- Reset (rst_n low at a sck edge):
  - state IDLE; adc_rst_o=1; all other outputs 0; internal counters 0.
  - adc_rst_o drops to 0 on the first edge after reset release.
  - err_count_o is cleared only by reset.
- IDLE:
  - adc_rst_o=0, so the ADC free-runs.
  - start_i=1 → latch burst_len_i; clear sum, count, timer, consec_err, retries; go to CAPTURE next edge.
- CAPTURE (timer increments every cycle; cleared on any adc_valid_i):
  - Good sample (adc_valid_i & !adc_error_i): sum += zero-extended adc_data_i; count++; consec_err=0.
    - If count reaches latched length+1 → DONE.
  - Error sample (adc_valid_i & adc_error_i): sample discarded; err_count_o++ (saturates at 255); consec_err++.
    - If consec_err reaches MAX_CONSEC_ERR → RESYNC.
  - timer reaches TIMEOUT-1 with no valid that cycle → RESYNC.
  - Good-sample completion and resync condition in the same cycle: completion wins.
- RESYNC:
  - adc_rst_o=1 for exactly RST_CYCLES cycles; adc_valid_i ignored; retries++ on entry.
  - If retries was already MAX_RETRIES on entry: go to DONE with fault=1 and no reset pulse.
  - Otherwise after RST_CYCLES: timer=0, consec_err=0, return to CAPTURE; partial sum/count are kept.
  - Timeout must cover ADC warm-up (3 acquisitions ≈ 54 cycles) plus RST_CYCLES; TIMEOUT ≥ 64 is required.
- DONE:
  - result_valid_o=1; sum_o/count_o/fault_o stable while valid and not ready.
  - Transfer on result_valid_o & result_ready_i → IDLE next edge; result_valid_o=0.
  - result_ready_i with no valid is ignored; start_i is ignored outside IDLE.
- Arithmetic: sum_o width LEN_W+12 cannot overflow (256×4095 = 1,048,320 < 2^20); no saturation logic.
- Outputs are registered. Latency from final good adc_valid_i to result_valid_o = 1 cycle.
- Reset mid-burst aborts the burst immediately; no result is produced.

Test Plan:
- burst_len_i=3, four good samples 0x100, 0x200, 0x300, 0xFFF, result_ready_i=1 → result_valid_o one cycle after 4th strobe; sum_o=0x15FF; count_o=4; fault_o=0; back to IDLE.
- burst_len_i=1, samples good 0x010, error, good 0x020 → sum_o=0x030; count_o=2; err_count_o=1; adc_rst_o stays 0.
- burst_len_i=7, 4 consecutive error strobes after 2 good → adc_rst_o high exactly 4 cycles; resume.
  - 6 further good samples after resume → count_o=8; fault_o=0.
- adc_valid_i held low in CAPTURE → RESYNC at cycle 128. This repeats 3 times; on the 4th timeout → DONE with fault_o=1, count_o=0, no 4th reset pulse.
- Result pending with result_ready_i=0 for 10 cycles while start_i pulses → outputs stable, start ignored. Then ready=1 → IDLE.
  - Next start_i is accepted.
- rst_n low mid-CAPTURE → next edge state IDLE, adc_rst_o=1, result_valid_o=0, err_count_o=0.
- Feed 300 error samples → err_count_o saturates at 255.

Source files
------------

// File: rtl/adc_burst_sequencer.sv
// Burst sequencer for the LTC2315 ADC interface (sck domain): accumulates a burst of
// good samples, drops error samples, resyncs the ADC on errors or stalls, and hands off a result.
module adc_burst_sequencer #(
  parameter int LEN_W          = 8,
  parameter int TIMEOUT        = 128,
  parameter int MAX_CONSEC_ERR = 4,
  parameter int RST_CYCLES     = 4,
  parameter int MAX_RETRIES    = 3
) (
  input  logic               sck,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [LEN_W-1:0]   burst_len_i,
  input  logic [11:0]        adc_data_i,
  input  logic               adc_valid_i,
  input  logic               adc_error_i,
  output logic               adc_rst_o,
  output logic               busy_o,
  output logic [LEN_W+11:0]  sum_o,
  output logic [LEN_W:0]     count_o,
  output logic               fault_o,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [7:0]         err_count_o
);

  localparam int TMR_W = $clog2(TIMEOUT);
  localparam int CE_W  = $clog2(MAX_CONSEC_ERR + 1);
  localparam int RT_W  = $clog2(MAX_RETRIES + 1);
  localparam int RC_W  = $clog2(RST_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, RESYNC, DONE} state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W+11:0]  sum_q;
  logic [LEN_W:0]     cnt_q;
  logic [TMR_W-1:0]   timer_q;
  logic [CE_W-1:0]    consec_q;
  logic [RT_W-1:0]    retries_q;
  logic [RC_W-1:0]    rcnt_q;
  logic               fault_q;
  logic               adc_rst_q;
  logic [7:0]         err_q;

  logic good, bad, last_good, resync_req, exhausted, rst_done;

  always_comb begin
    good       = adc_valid_i & ~adc_error_i;
    bad        = adc_valid_i &  adc_error_i;
    last_good  = good && (cnt_q == {1'b0, len_q});
    resync_req = (bad && (consec_q == CE_W'(MAX_CONSEC_ERR - 1)))
              || (!adc_valid_i && (timer_q == TMR_W'(TIMEOUT - 1)));
    exhausted  = (retries_q == RT_W'(MAX_RETRIES));
    rst_done   = (rcnt_q == RC_W'(RST_CYCLES - 1));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = CAPTURE;
      // completion takes priority; an exhausted retry budget skips the reset pulse entirely
      CAPTURE: if (last_good)       state_d = DONE;
               else if (resync_req) state_d = exhausted ? DONE : RESYNC;
      RESYNC:  if (rst_done) state_d = CAPTURE;
      DONE:    if (result_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sck) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      timer_q   <= '0;
      consec_q  <= '0;
      retries_q <= '0;
      rcnt_q    <= '0;
      fault_q   <= 1'b0;
      adc_rst_q <= 1'b1;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      adc_rst_q <= (state_d == RESYNC);
      case (state_q)
        IDLE: if (start_i) begin
          len_q     <= burst_len_i;
          sum_q     <= '0;
          cnt_q     <= '0;
          timer_q   <= '0;
          consec_q  <= '0;
          retries_q <= '0;
          fault_q   <= 1'b0;
        end
        CAPTURE: begin
          timer_q <= adc_valid_i ? '0 : timer_q + TMR_W'(1);
          if (good) begin
            sum_q    <= sum_q + (LEN_W+12)'(adc_data_i);
            cnt_q    <= cnt_q + (LEN_W+1)'(1);
            consec_q <= '0;
          end
          if (bad) begin
            if (err_q != 8'hFF) err_q <= err_q + 8'd1;
            consec_q <= consec_q + CE_W'(1);
          end
          if (resync_req && !last_good) begin
            if (exhausted) fault_q <= 1'b1;
            else begin
              retries_q <= retries_q + RT_W'(1);
              rcnt_q    <= '0;
            end
          end
        end
        RESYNC: begin
          rcnt_q <= rcnt_q + RC_W'(1);
          if (rst_done) begin
            timer_q  <= '0;
            consec_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign adc_rst_o      = adc_rst_q;
  assign busy_o         = (state_q != IDLE);
  assign result_valid_o = (state_q == DONE);
  assign sum_o          = sum_q;
  assign count_o        = cnt_q;
  assign fault_o        = fault_q;
  assign err_count_o    = err_q;

endmodule

// File: tb/tb_adc_burst_sequencer.sv
// Directed bench for adc_burst_sequencer with a burst-level reference model checked every cycle.
module tb_adc_burst_sequencer;

  localparam int LEN_W = 8;

  logic              sck = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_i = 1'b0;
  logic [LEN_W-1:0]  burst_len_i = '0;
  logic [11:0]       adc_data_i = '0;
  logic              adc_valid_i = 1'b0;
  logic              adc_error_i = 1'b0;
  logic              adc_rst_o;
  logic              busy_o;
  logic [LEN_W+11:0] sum_o;
  logic [LEN_W:0]    count_o;
  logic              fault_o;
  logic              result_valid_o;
  logic              result_ready_i = 1'b0;
  logic [7:0]        err_count_o;

  adc_burst_sequencer #(
    .LEN_W(LEN_W), .TIMEOUT(128), .MAX_CONSEC_ERR(4), .RST_CYCLES(4), .MAX_RETRIES(3)
  ) dut (
    .sck(sck), .rst_n(rst_n), .start_i(start_i), .burst_len_i(burst_len_i),
    .adc_data_i(adc_data_i), .adc_valid_i(adc_valid_i), .adc_error_i(adc_error_i),
    .adc_rst_o(adc_rst_o), .busy_o(busy_o), .sum_o(sum_o), .count_o(count_o),
    .fault_o(fault_o), .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .err_count_o(err_count_o)
  );

  always #5 sck = ~sck;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase of the burst plus plain counters of what has happened.
  localparam int P_IDLE = 0, P_CAP = 1, P_RES = 2, P_DONE = 3;
  int m_phase = P_IDLE;
  int m_len, m_sum, m_cnt, m_idle, m_consec, m_retry, m_rleft;
  int m_err = 0;
  bit m_fault = 0, m_rst = 1;
  bit cmp_en = 0;
  int cur_len = 0;

  task automatic begin_resync();
    if (m_retry == 3) begin
      m_phase = P_DONE;
      m_fault = 1;
    end else begin
      m_retry++;
      m_rleft = 4;
      m_rst = 1;
      m_phase = P_RES;
    end
  endtask

  task automatic model(input bit st, input bit v, input bit e, input int d, input bit rdy);
    if (!rst_n) begin
      m_phase = P_IDLE; m_sum = 0; m_cnt = 0; m_err = 0; m_fault = 0; m_rst = 1;
    end else begin
      case (m_phase)
        P_IDLE: begin
          m_rst = 0;
          if (st) begin
            m_phase = P_CAP; m_len = cur_len; m_sum = 0; m_cnt = 0;
            m_idle = 0; m_consec = 0; m_retry = 0; m_fault = 0;
          end
        end
        P_CAP: begin
          if (v && !e) begin
            m_sum += d; m_cnt++; m_consec = 0; m_idle = 0;
            if (m_cnt == m_len + 1) m_phase = P_DONE;
          end else if (v) begin
            if (m_err < 255) m_err++;
            m_consec++; m_idle = 0;
            if (m_consec == 4) begin_resync();
          end else begin
            m_idle++;
            if (m_idle == 128) begin_resync();
          end
        end
        P_RES: begin
          m_rleft--;
          if (m_rleft == 0) begin
            m_phase = P_CAP; m_rst = 0; m_idle = 0; m_consec = 0;
          end
        end
        default: if (rdy) m_phase = P_IDLE;
      endcase
    end
  endtask

  task automatic step(input bit st, input bit v, input bit e, input int d, input bit rdy);
    start_i = st; adc_valid_i = v; adc_error_i = e; adc_data_i = 12'(d);
    result_ready_i = rdy; burst_len_i = LEN_W'(cur_len);
    @(posedge sck);
    #1;
    model(st, v, e, d, rdy);
  endtask

  always @(negedge sck) begin
    if (cmp_en) begin
      check("adc_rst", int'(adc_rst_o), int'(m_rst));
      check("busy", int'(busy_o), int'(m_phase != P_IDLE));
      check("result_valid", int'(result_valid_o), int'(m_phase == P_DONE));
      check("err_count", int'(err_count_o), m_err);
      if (m_phase == P_DONE) begin
        check("sum", int'(sum_o), m_sum);
        check("count", int'(count_o), m_cnt);
        check("fault", int'(fault_o), int'(m_fault));
      end
    end
  end

  initial begin
    int rc;
    rst_n = 0;
    step(0, 0, 0, 0, 0);
    cmp_en = 1;
    step(0, 0, 0, 0, 0);
    check("rst_adc_rst", int'(adc_rst_o), 1);
    check("rst_busy", int'(busy_o), 0);
    check("rst_sum", int'(sum_o), 0);
    check("rst_count", int'(count_o), 0);
    check("rst_valid", int'(result_valid_o), 0);
    check("rst_err", int'(err_count_o), 0);
    rst_n = 1;
    step(0, 0, 0, 0, 0);
    check("rel_adc_rst", int'(adc_rst_o), 0);

    // four good samples, ready held high
    cur_len = 3;
    step(1, 0, 0, 0, 1);
    step(0, 1, 0, 'h100, 1);
    step(0, 1, 0, 'h200, 1);
    step(0, 1, 0, 'h300, 1);
    step(0, 1, 0, 'hFFF, 1);
    check("t1_valid", int'(result_valid_o), 1);
    check("t1_sum", int'(sum_o), 'h15FF);
    check("t1_count", int'(count_o), 4);
    check("t1_fault", int'(fault_o), 0);
    step(0, 0, 0, 0, 1);
    check("t1_idle", int'(busy_o), 0);

    // one error sample in between
    cur_len = 1;
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 'h010, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 'h7AA, 0);
    step(0, 1, 0, 'h020, 0);
    check("t2_sum", int'(sum_o), 'h030);
    check("t2_count", int'(count_o), 2);
    check("t2_err", int'(err_count_o), 1);
    check("t2_adc_rst", int'(adc_rst_o), 0);
    step(0, 0, 0, 0, 1);

    // four consecutive errors force a resync, then the burst completes
    cur_len = 7;
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 2, 0);
    repeat (4) step(0, 1, 1, 0, 0);
    rc = int'(adc_rst_o);
    repeat (5) begin
      step(0, 0, 0, 0, 0);
      rc += int'(adc_rst_o);
    end
    check("t3_rst_len", rc, 4);
    for (int i = 3; i <= 8; i++) step(0, 1, 0, i, 0);
    check("t3_count", int'(count_o), 8);
    check("t3_sum", int'(sum_o), 36);
    check("t3_fault", int'(fault_o), 0);
    step(0, 0, 0, 0, 1);

    // stalls: three resyncs, fourth timeout ends the burst with a fault
    cur_len = 0;
    step(1, 0, 0, 0, 0);
    for (int a = 0; a < 4; a++) begin
      repeat (127) step(0, 0, 0, 0, 0);
      check("t4_pre_tmo", int'(adc_rst_o), 0);
      step(0, 0, 0, 0, 0);
      if (a < 3) begin
        check("t4_pulse", int'(adc_rst_o), 1);
        repeat (4) step(0, 0, 0, 0, 0);
      end
    end
    check("t4_valid", int'(result_valid_o), 1);
    check("t4_fault", int'(fault_o), 1);
    check("t4_count", int'(count_o), 0);
    check("t4_no_pulse", int'(adc_rst_o), 0);

    // result held with ready low; start pulses ignored
    for (int i = 0; i < 10; i++) step(bit'(i % 2), 0, 0, 0, 0);
    check("t5_hold_valid", int'(result_valid_o), 1);
    check("t5_hold_fault", int'(fault_o), 1);
    step(1, 0, 0, 0, 1);
    check("t5_idle", int'(busy_o), 0);
    cur_len = 255;
    step(1, 0, 0, 0, 0);
    check("t5_restart", int'(busy_o), 1);

    // 300 error samples, never four in a row
    for (int i = 0; i < 100; i++) begin
      repeat (3) step(0, 1, 1, 0, 0);
      step(0, 1, 0, 1, 0);
    end
    check("sat_err", int'(err_count_o), 255);
    check("sat_count", int'(count_o), 100);

    // reset in the middle of capture
    rst_n = 0;
    step(0, 0, 0, 0, 0);
    check("mid_rst_busy", int'(busy_o), 0);
    check("mid_rst_adc_rst", int'(adc_rst_o), 1);
    check("mid_rst_valid", int'(result_valid_o), 0);
    check("mid_rst_err", int'(err_count_o), 0);
    rst_n = 1;
    repeat (3) step(0, 0, 0, 0, 0);

    cmp_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
